// File: rtl/fir_window_feeder.sv
// fir_window_feeder: buffers one raster row of reference pixels and replays it
// as the overlapping TAPS-wide windows consumed by the FIR filter bank.
`default_nettype none

module fir_window_feeder #(
  parameter int NUM_PIXEL = 8,
  parameter int PIXEL_W   = 8,
  parameter int TAPS      = 8,
  parameter int ROW_W     = $clog2(NUM_PIXEL + TAPS - 1),
  parameter int COL_W     = $clog2(NUM_PIXEL)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [PIXEL_W-1:0]        s_pixel,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [TAPS*PIXEL_W-1:0]   m_window,
  output logic [ROW_W-1:0]          m_row,
  output logic [COL_W-1:0]          m_col,
  output logic                      m_last
);

  localparam int               ROW_LEN  = NUM_PIXEL + TAPS - 1;
  localparam logic [ROW_W-1:0] LAST_IDX = ROW_W'(ROW_LEN - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_PIXEL - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   fill_q, fill_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [PIXEL_W-1:0] rowbuf_q [ROW_LEN];
  logic               wr_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      fill_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      for (int i = 0; i < ROW_LEN; i++) rowbuf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      row_q   <= row_d;
      col_q   <= col_d;
      if (flush) begin
        for (int i = 0; i < ROW_LEN; i++) rowbuf_q[i] <= '0;
      end else if (wr_en) begin
        rowbuf_q[fill_q] <= s_pixel;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    row_d   = row_q;
    col_d   = col_q;
    wr_en   = 1'b0;
    // flush takes priority and swallows any handshake in the same cycle
    if (flush) begin
      state_d = FILL;
      fill_d  = '0;
      row_d   = '0;
      col_d   = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (s_valid) begin
            wr_en = 1'b1;
            if (fill_q == LAST_IDX) begin
              state_d = EMIT;
              fill_d  = '0;
              col_d   = '0;
            end else begin
              fill_d = fill_q + ROW_W'(1);
            end
          end
        end
        EMIT: begin
          if (m_ready) begin
            if (col_q != LAST_COL) begin
              col_d = col_q + COL_W'(1);
            end else begin
              col_d   = '0;
              fill_d  = '0;
              state_d = FILL;
              row_d   = (row_q == LAST_IDX) ? '0 : row_q + ROW_W'(1);
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // The buffer is frozen during EMIT, so each tap is a pure function of col_q.
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    assign m_window[k*PIXEL_W +: PIXEL_W] = rowbuf_q[ROW_W'(col_q) + ROW_W'(k)];
  end

  assign s_ready = (state_q == FILL);
  assign m_valid = (state_q == EMIT);
  assign m_row   = row_q;
  assign m_col   = col_q;
  assign m_last  = m_valid && (row_q == LAST_IDX) && (col_q == LAST_COL);

endmodule

`default_nettype wire

// File: tb/tb_fir_window_feeder.sv
// Bench for fir_window_feeder: directed scenarios plus random pixels/stalls,
// checked against a row-array window model.
`default_nettype none

module tb_fir_window_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic [7:0]  s_pixel = 8'h00;
  logic        s_ready;
  logic        m_valid;
  logic [63:0] m_window;
  logic [3:0]  m_row;
  logic [2:0]  m_col;
  logic        m_last;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] got [15][8];

  fir_window_feeder dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_pixel  (s_pixel),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_window (m_window),
    .m_row    (m_row),
    .m_col    (m_col),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] win(input logic [7:0] p [15], input int c);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = p[c+k];
    return w;
  endfunction

  // mode 0: full block; 1: async reset at row 5 col 4; 2: flush with handshake at row 3 col 6
  task automatic run_block(input int mode, input bit bubbles, input bit rnd_pix,
                           input int stall_r, input int stall_c, input bit rnd_stall);
    logic [7:0] px [15];
    int acc, guard, col, stall;
    bit tog;
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 15; c++) px[c] = rnd_pix ? 8'($urandom) : 8'(16*r + c);
      acc = 0; guard = 0; tog = 1'b0;
      while (acc < 15 && guard < 100) begin
        @(negedge clk);
        guard++;
        chk("fill_s_ready", s_ready, 1);
        chk("fill_m_valid", m_valid, 0);
        chk("fill_m_row", m_row, r);
        m_ready = 1'($urandom);
        tog = ~tog;
        s_valid = bubbles ? tog : 1'b1;
        s_pixel = s_valid ? px[acc] : 8'($urandom);
        if (s_valid) acc++;
      end
      chk("fill_timeout", guard < 100, 1);
      col = 0; guard = 0; stall = 0;
      while (col < 8 && guard < 100) begin
        @(negedge clk);
        guard++;
        s_valid = 1'b0;
        s_pixel = 8'($urandom);
        chk("emit_m_valid", m_valid, 1);
        chk("emit_s_ready", s_ready, 0);
        chk("emit_window", m_window, win(px, col));
        chk("emit_row", m_row, r);
        chk("emit_col", m_col, col);
        chk("emit_last", m_last, (r == 14 && col == 7));
        got[r][col] = m_window;
        if (mode == 1 && r == 5 && col == 4) begin
          m_ready = 1'b0;
          reset = 1'b0;
          #1;
          chk("rst_m_valid", m_valid, 0);
          chk("rst_m_window", m_window, 0);
          chk("rst_m_row", m_row, 0);
          chk("rst_m_col", m_col, 0);
          chk("rst_m_last", m_last, 0);
          chk("rst_s_ready", s_ready, 1);
          @(negedge clk);
          reset = 1'b1;
          return;
        end
        if (mode == 2 && r == 3 && col == 6) begin
          m_ready = 1'b1;
          flush = 1'b1;
          @(negedge clk);
          flush = 1'b0;
          m_ready = 1'b0;
          chk("flush_m_valid", m_valid, 0);
          chk("flush_s_ready", s_ready, 1);
          chk("flush_m_row", m_row, 0);
          chk("flush_m_col", m_col, 0);
          chk("flush_m_window", m_window, 0);
          chk("flush_m_last", m_last, 0);
          return;
        end
        if (r == stall_r && col == stall_c && stall < 5) begin
          m_ready = 1'b0;
          stall++;
        end else begin
          m_ready = rnd_stall ? ($urandom_range(2) != 0) : 1'b1;
        end
        if (m_ready) col++;
      end
      chk("emit_timeout", guard < 100, 1);
    end
    @(negedge clk);
    m_ready = 1'b0;
    chk("end_m_valid", m_valid, 0);
    chk("end_s_ready", s_ready, 1);
    chk("end_m_row", m_row, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_s_ready", s_ready, 1);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_window", m_window, 0);
    chk("reset_m_row", m_row, 0);
    chk("reset_m_col", m_col, 0);
    chk("reset_m_last", m_last, 0);
    reset = 1'b1;

    run_block(0, 1'b0, 1'b0, -1, -1, 1'b0);
    chk("ramp_r0c0", got[0][0], 64'h0706050403020100);
    chk("ramp_r0c7", got[0][7], 64'h0E0D0C0B0A090807);
    chk("ramp_r14c0", got[14][0], 64'hE7E6E5E4E3E2E1E0);

    run_block(0, 1'b0, 1'b0, 2, 3, 1'b0);
    chk("stall_r2c3", got[2][3], 64'h2A29282726252423);
    chk("stall_r2c4", got[2][4], 64'h2B2A292827262524);

    run_block(0, 1'b1, 1'b0, -1, -1, 1'b0);
    chk("bubble_r0c0", got[0][0], 64'h0706050403020100);
    chk("bubble_r14c7", got[14][7], 64'hEEEDECEBEAE9E8E7);

    run_block(0, 1'b1, 1'b1, -1, -1, 1'b1);

    run_block(1, 1'b0, 1'b0, -1, -1, 1'b0);
    run_block(0, 1'b0, 1'b0, -1, -1, 1'b0);
    chk("post_reset_r0c0", got[0][0], 64'h0706050403020100);

    run_block(2, 1'b0, 1'b0, -1, -1, 1'b0);
    run_block(0, 1'b0, 1'b1, -1, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
